// File: rtl/k2_controller.sv
// k2_controller: fetch/execute sequencer for the K2 teaching CPU.
// Owns pc, the instruction register and the carry flag; register file and memories live outside.
module k2_controller #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  input  logic [7:0]      inst,
  input  logic            carry_in,
  output logic            ra_we,
  output logic            rb_we,
  output logic            ro_we,
  output logic [1:0]      src_sel,
  output logic [2:0]      imm,
  output logic [2:0]      mem_addr,
  output logic            mem_we,
  output logic            mem_re,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_JC   = 2'b01;
  localparam logic [1:0] OP_J    = 2'b10;

  localparam logic [1:0] DST_RA  = 2'b00;
  localparam logic [1:0] DST_RB  = 2'b01;
  localparam logic [1:0] DST_RO  = 2'b10;

  localparam logic [1:0] SRC_SUM = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_RA  = 2'd2;
  localparam logic [1:0] SRC_MEM = 2'd3;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, jump_tgt;
  logic [7:0]      ir_q, ir_d;
  logic            flag_q, flag_d;
  logic [1:0]      opcode, dest;

  assign opcode   = ir_q[7:6];
  assign dest     = ir_q[5:4];
  assign pc_inc   = pc_q + PC_W'(1);
  assign jump_tgt = PC_W'(ir_q[3:0]);

  assign pc       = pc_q;
  assign state    = state_q;
  assign imm      = ir_q[2:0];
  assign mem_addr = ir_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
    end
  end

  // Strobes are decoded purely from the registered state and IR, so reset silences them at once.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    ra_we   = 1'b0;
    rb_we   = 1'b0;
    ro_we   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    src_sel = SRC_SUM;

    case (state_q)
      EXEC: begin
        pc_d    = pc_inc;
        state_d = FETCH;
        case (opcode)
          OP_ALU: begin
            if (ir_q[3]) begin
              src_sel = SRC_IMM;
            end else if (dest == DST_RO) begin
              src_sel = SRC_RA;
            end else begin
              src_sel = SRC_SUM;
            end
            ra_we = (dest == DST_RA);
            rb_we = (dest == DST_RB);
            ro_we = (dest == DST_RO);
            if (!ir_q[3] && !dest[1]) begin
              flag_d = carry_in;
            end
          end
          OP_JC: begin
            if (flag_q) begin
              pc_d   = jump_tgt;
              flag_d = 1'b0;
            end
          end
          OP_J: begin
            pc_d = jump_tgt;
          end
          // Memory class: IR[5] picks store versus two-cycle load.
          default: begin
            if (ir_q[5]) begin
              mem_we = 1'b1;
            end else begin
              mem_re  = 1'b1;
              pc_d    = pc_q;
              state_d = LOAD;
            end
          end
        endcase
      end

      LOAD: begin
        src_sel = SRC_MEM;
        ra_we   = !ir_q[4];
        rb_we   = ir_q[4];
        pc_d    = pc_inc;
        state_d = FETCH;
      end

      // FETCH, and the unused encoding which recovers into FETCH.
      default: begin
        if (run) begin
          ir_d    = inst;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
    endcase
  end

endmodule

// File: doc/k2_controller.md
K2_CONTROLLER -- requirements
Module: k2_controller

Interface
REQ-001 Parameter PC_W, default 4, program-counter and program-ROM address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  when 1, the FSM advances; when 0, the FSM holds in FETCH.
REQ-006 pc  output  PC_W  program-ROM address (drives ROM select input).
REQ-007 inst  input  8  ROM instruction, combinational from pc.
REQ-008 carry_in  input  1  ALU carry-out of RA+RB.
REQ-009 ra_we, rb_we, ro_we  output  1 each  register write enables, one-cycle pulses.
REQ-010 src_sel  output  2  write-data source: 0=ALU sum, 1=immediate, 2=RA, 3=data memory.
REQ-011 imm  output  3  immediate value, equal to IR[2:0].
REQ-012 mem_addr  output  3  data-memory address, equal to IR[2:0].
REQ-013 mem_we, mem_re  output  1 each  data-memory write (data=RA) and read strobes.
REQ-014 state  output  2  current FSM state, for debug.

Function
REQ-015 The FSM shall have states FETCH=0, EXEC=1, LOAD=2; value 3 shall be unreachable and decode to FETCH.
REQ-016 In FETCH with run=1, the block shall latch inst into the 8-bit IR and go to EXEC; with run=0 it shall stay in FETCH and leave IR and pc unchanged.
REQ-017 In FETCH, all write/strobe outputs shall be 0.
REQ-018 Decode on IR[7:6]: 00=ALU/move, 01=JC, 10=J, 11=memory.
REQ-019 ALU/move: destination IR[5:4] (00=RA, 01=RB, 10=RO, 11=no write); IR[3]=1 selects the immediate (src_sel=1); IR[3]=0 selects the ALU sum (src_sel=0) for RA/RB and RA (src_sel=2) for RO.
REQ-020 ALU/move shall assert the selected write enable for exactly the EXEC cycle, then set pc=pc+1 and go to FETCH.
REQ-021 The carry flag shall be loaded from carry_in only on EXEC of an ALU/move with IR[3]=0 and destination RA or RB; it is unchanged otherwise.
REQ-022 J: pc shall load {0,IR[3:0]} zero-extended to PC_W at the end of EXEC; the flag is unchanged.
REQ-023 JC: pc shall load the same target if the flag=1, else pc=pc+1; the flag shall be cleared after a taken JC.
REQ-024 Memory with IR[5]=1 (store): mem_we=1 for the EXEC cycle, then pc=pc+1 and go to FETCH; IR[4] is ignored.
REQ-025 Memory with IR[5]=0 (load): mem_re=1 in EXEC and go to LOAD; in LOAD, src_sel=3 and ra_we (IR[4]=0) or rb_we (IR[4]=1) shall be asserted for one cycle, then pc=pc+1 and go to FETCH.
REQ-026 Latency shall be 2 cycles per instruction (FETCH+EXEC), except load, which takes 3 cycles.
REQ-027 PC increment shall wrap modulo 2^PC_W (15 -> 0 at the default width).
REQ-028 When run drops mid-instruction, the current instruction shall complete; the hold applies only at the next FETCH.
REQ-029 At most one of ra_we/rb_we/ro_we/mem_we shall be asserted in any cycle.

Reset
REQ-030 On rst_n=0, the block shall immediately set state=FETCH, pc=RESET_PC, IR=0, and flag=0, and drive all write enables and strobes to 0, independent of clk.
REQ-031 A reset asserted in EXEC or LOAD shall abort the instruction with no write pulse after assertion.
REQ-032 After rst_n deasserts, the first fetch shall occur on the first rising edge with run=1.

Verification
REQ-033 Reset, run=1, inst=0000_1001 -> cycle 2: ra_we=1, src_sel=1, imm=1; pc=1 after.
REQ-034 inst=1100_1001 at pc=5 -> EXEC: mem_re=1, mem_addr=1; LOAD: ra_we=1, src_sel=3; pc=6 after 3 cycles.
REQ-035 RA+RB with carry_in=1, then 0111_0000 -> pc=0 and flag=0; the same sequence with carry_in=0 -> pc advances by 1.
REQ-036 1011_0110 at pc=11 -> pc=6; pc=15 with a non-jump instruction -> pc=0.
REQ-037 run=0 in FETCH for 5 cycles -> pc, IR, and state unchanged, with no strobes; rst_n pulsed low in LOAD -> no rb_we, pc=0, state=0.
